// File: rtl/imem_loader.sv
// Packs a valid/ready byte stream into little-endian 32-bit words and writes them to imem from a latched base.
// Latency: first byte_ready 1 cycle after start; 4 collect cycles + 1 write cycle per word, done 1 cycle after the last write.
// Backpressure: byte_ready only in COLLECT; a silent source stalls the load indefinitely, abort cancels it.
module imem_loader #(
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q, len_q, word_idx, addr_q;
  logic [1:0]        byte_idx;
  logic [31:0]       word_q, data_q;
  logic              err_q;
  logic [ADDR_W:0]   end_addr;
  logic              range_bad, xfer, wr_fire, last_word;

  // End address is one bit wider than the port so base+length cannot wrap.
  assign end_addr  = {1'b0, base_addr} + {1'b0, length};
  assign range_bad = end_addr > (ADDR_W+1)'(MEM_DEPTH);
  assign xfer      = (state == COLLECT) && byte_valid && !abort;
  assign wr_fire   = (state == WRITE) && !abort;
  assign last_word = (word_idx + ADDR_W'(1)) == len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= length;
            err_q    <= (length != '0) && range_bad;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        COLLECT: begin
          if (abort) begin
            byte_idx <= '0;
          end else if (xfer) begin
            word_q[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx                        <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          // Capture what was presented so the port holds it once wr_en drops.
          if (wr_fire) begin
            addr_q   <= base_q + word_idx;
            data_q   <= word_q;
            word_idx <= word_idx + ADDR_W'(1);
            byte_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    wr_addr    = addr_q;
    wr_data    = data_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0 || range_bad) state_nxt = DONE;
          else                           state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (abort)                          state_nxt = IDLE;
        else if (xfer && byte_idx == 2'd3)  state_nxt = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          wr_en     = 1'b1;
          wr_addr   = base_q + word_idx;
          wr_data   = word_q;
          state_nxt = last_word ? DONE : COLLECT;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_hold = busy;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; writes and done pulses are checked by a negedge monitor against queued expectations.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, busy, cpu_hold, done, err;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  int brdy_cnt = 0;
  int done_cnt = 0;

  logic [15:0] q_addr[$];
  logic [31:0] q_data[$];
  logic        q_err[$];

  imem_loader #(.ADDR_W(16), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (byte_ready) brdy_cnt++;
    if (cpu_hold !== busy) begin
      checks++;
      failures++;
      $display("FAIL cpu_hold: got %b want %b", cpu_hold, busy);
    end
    if (wr_en) begin
      if (q_addr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected write: got addr %h data %h want no write", wr_addr, wr_data);
      end else begin
        chk("wr_addr", 32'(wr_addr), 32'(q_addr.pop_front()));
        chk("wr_data", wr_data, q_data.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      if (q_err.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected done: got done=1 want done=0");
      end else begin
        chk("err at done", 32'(err), 32'(q_err.pop_front()));
      end
    end
  end

  task automatic do_start(input logic [15:0] b, input logic [15:0] l, input logic ab);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  // Sends n bytes from the low end of bytes; after byte stall_idx, holds byte_valid low for stall_cyc cycles.
  task automatic send_bytes(input logic [63:0] bytes, input int n, input int stall_idx, input int stall_cyc);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      byte_data  = bytes[8*i +: 8];
      byte_valid = 1'b1;
      @(negedge clk);
      while (!byte_ready && w < 50) begin
        w++;
        @(negedge clk);
      end
      if (!byte_ready) begin
        checks++;
        failures++;
        $display("FAIL byte_ready timeout: got 0 want 1 within 50 cycles");
        byte_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (i == stall_idx) begin
        byte_valid = 1'b0;
        repeat (stall_cyc) @(posedge clk);
        #1;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done timeout: got no done want done within %0d cycles", budget);
    end
  endtask

  // Two-word load of 0x12345678 / 0xDEADBEEF at base, optionally stalling the source.
  task automatic run_load(input logic [15:0] b, input int stall_idx, input int stall_cyc, input int exp_busy);
    int b0, d0;
    q_addr.push_back(b);                 q_data.push_back(32'h12345678);
    q_addr.push_back(b + 16'd1);         q_data.push_back(32'hDEADBEEF);
    q_err.push_back(1'b0);
    b0 = busy_cnt; d0 = done_cnt;
    do_start(b, 16'd2, 1'b0);
    chk("start->byte_ready latency", 32'(byte_ready), 32'd1);
    send_bytes(64'h12345678, 4, stall_idx, stall_cyc);
    chk("byte_ready low in write", 32'(byte_ready), 32'd0);
    chk("wr_en after 4th byte", 32'(wr_en), 32'd1);
    send_bytes(64'hDEADBEEF, 4, -1, 0);
    wait_done(40);
    repeat (2) @(posedge clk);
    #1;
    chk("busy cycles", 32'(busy_cnt - b0), 32'(exp_busy));
    chk("done pulses", 32'(done_cnt - d0), 32'd1);
    chk("writes left", 32'(q_addr.size()), 32'd0);
  endtask

  initial begin
    int b0, r0;
    #2;
    chk("rst byte_ready", 32'(byte_ready), 32'd0);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst wr_data", wr_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic back-to-back load, then the same stream with a 3-cycle source gap.
    run_load(16'h0010, -1, 0, 10);
    run_load(16'h0010, 1, 3, 13);

    // Range error: 0x3FF + 2 exceeds 1024 words.
    q_err.push_back(1'b1);
    b0 = busy_cnt;
    do_start(16'h03FF, 16'd2, 1'b0);
    wait_done(5);
    @(posedge clk); #1;
    chk("range err sticky", 32'(err), 32'd1);
    chk("range busy cycles", 32'(busy_cnt - b0), 32'd0);

    // Last legal word: 0x3FF + 1 == 1024, and the accepted start clears err.
    q_addr.push_back(16'h03FF); q_data.push_back(32'h04030201); q_err.push_back(1'b0);
    do_start(16'h03FF, 16'd1, 1'b0);
    chk("err cleared by start", 32'(err), 32'd0);
    send_bytes(64'h04030201, 4, -1, 0);
    wait_done(10);

    // Zero length: done the cycle after start, no byte_ready.
    q_err.push_back(1'b0);
    b0 = busy_cnt; r0 = brdy_cnt;
    do_start(16'h0020, 16'd0, 1'b0);
    chk("zero-length done", 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("zero-length byte_ready cycles", 32'(brdy_cnt - r0), 32'd0);
    chk("zero-length busy cycles", 32'(busy_cnt - b0), 32'd0);

    // Abort after two bytes of a one-word load.
    do_start(16'h0040, 16'd1, 1'b0);
    send_bytes(64'h00002211, 2, -1, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort byte_ready", 32'(byte_ready), 32'd0);
    chk("abort keeps wr_addr", 32'(wr_addr), 32'h000003FF);
    chk("abort keeps wr_data", wr_data, 32'h04030201);
    // Fresh load with abort raised alongside start in IDLE: start wins.
    q_addr.push_back(16'h0040); q_data.push_back(32'hDDCCBBAA); q_err.push_back(1'b0);
    do_start(16'h0040, 16'd1, 1'b1);
    chk("start beats abort in idle", 32'(busy), 32'd1);
    send_bytes(64'hDDCCBBAA, 4, -1, 0);
    wait_done(10);

    // Asynchronous reset between edges in COLLECT.
    do_start(16'h0050, 16'd2, 1'b0);
    send_bytes(64'h00005566, 2, -1, 0);
    #3;
    rst = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst byte_ready", 32'(byte_ready), 32'd0);
    chk("async rst wr_addr", 32'(wr_addr), 32'd0);
    chk("async rst wr_data", wr_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_load(16'h0010, -1, 0, 10);

    repeat (3) @(posedge clk);
    chk("scoreboard drained", 32'(q_addr.size() + q_err.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction ROM/counter read path.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into 32-bit little-endian words.
- Writes each word into instruction memory at consecutive word addresses from a latched base.
- Holds the processor stalled via cpu_hold while loading, and reports done or error.

Parameters:
- ADDR_W, 16, word-address width of the memory write port.
- MEM_DEPTH, 1024, number of 32-bit words in instruction memory. Legal writes span 0..MEM_DEPTH-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load. Sampled only in IDLE.
- base_addr  in  ADDR_W  first word address. Latched when start is accepted.
- length  in  ADDR_W  number of words to load. Latched when start is accepted.
- abort  in  1  synchronous cancel; effective in any non-IDLE state.
- byte_data  in  8  incoming byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  memory word address.
- wr_data  out  32  memory write data.
- busy  out  1  high in COLLECT and WRITE.
- cpu_hold  out  1  equals busy; processor program counter must not advance while high.
- done  out  1  one-cycle pulse when a load completes, including zero-length loads.
- err  out  1  sticky range error. Cleared by the next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE. byte_ready, wr_en, busy, cpu_hold, done and err = 0. wr_addr, wr_data, byte index, word counter and latched registers = 0.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE, start=1:
  - Latch base_addr and length; clear err.
  - If length==0: go to DONE.
  - Else if base_addr+length > MEM_DEPTH (computed at ADDR_W+1 bits, no wrap): set err=1 and go to DONE. No write is issued.
  - Otherwise: go to COLLECT with byte index=0.
- IDLE, start=0: remain in IDLE.
- COLLECT:
  - byte_ready=1, registered, asserted the first cycle in COLLECT.
  - A byte transfers when byte_valid && byte_ready.
  - Byte k (k=0..3) of a word lands in bits [8k+7:8k] (little-endian).
  - byte_valid=0 stalls indefinitely with no timeout.
  - On the 4th transfer, go to WRITE. byte_ready=0 the following cycle.
- WRITE: exactly one cycle.
  - wr_en=1; wr_addr=base+word index; wr_data=assembled word.
  - Next cycle: word index+1.
  - If this was the last word, go to DONE; else go to COLLECT with byte index=0.
- DONE: done=1 for one cycle, then IDLE. cpu_hold=0 in DONE.
- Throughput: at most 1 byte per cycle. Minimum 5 cycles per word (4 COLLECT + 1 WRITE).
- Latency: start to first byte_ready = 1 cycle.
- start while busy: ignored.
- abort:
  - Takes priority over byte transfer and over WRITE.
  - Next state is IDLE; the partial word is discarded and no wr_en is issued that cycle.
  - done is not pulsed; err is unchanged.
- abort and start in the same IDLE cycle: abort is ignored and start is accepted.
- wr_addr and wr_data hold their last values when wr_en=0.
- Asserting rst mid-load: immediate return to reset values. Memory contents already written are left as-is.

Test Plan:
- Basic load: start, base=0x0010, length=2, bytes 78 56 34 12 EF BE AD DE back-to-back -> wr_en at 0x0010 with 0x12345678, then at 0x0011 with 0xDEADBEEF. done pulses once; busy is high for exactly 10 cycles.
- Stalling source: same stream with byte_valid low for 3 cycles between bytes 1 and 2 -> identical writes; no byte is lost or duplicated; no wr_en occurs before the 4th byte.
- Range error: MEM_DEPTH=1024, base=0x03FF, length=2 -> err=1 and done pulses. No wr_en; busy stays 0. A subsequent valid start clears err.
- Zero length: start with length=0 -> done pulses 1 cycle after start. No byte_ready; no wr_en.
- Abort mid-word: length=1, send 2 bytes, then abort=1 -> IDLE next cycle with no wr_en and no done. A new start with 4 bytes AA BB CC DD writes 0xDDCCBBAA.
- Async reset during COLLECT: drop rst between edges -> all outputs 0 immediately. Start after release behaves as the basic load case.
